// File: rtl/code_lock_pkg.sv
// code_lock_pkg: shared types and parameter-legality helpers for the serial code lock.
//   code_lock_state_t : FSM state encoding (COLLECT, CHECK, OPEN, PROGRAM, LOCKOUT)
//   MIN_*             : smallest legal values of the configuration parameters
//   params_legal()    : returns 1 when a parameter set is usable
package code_lock_pkg;

  typedef enum logic [2:0] {
    COLLECT = 3'd0,
    CHECK   = 3'd1,
    OPEN    = 3'd2,
    PROGRAM = 3'd3,
    LOCKOUT = 3'd4
  } code_lock_state_t;

  localparam int MIN_CODE_W      = 1;
  localparam int MIN_MAX_TRIES   = 1;
  localparam int MIN_LOCKOUT_CYC = 1;

  function automatic bit params_legal(input int code_w, input int max_tries, input int lockout_cyc);
    return (code_w >= MIN_CODE_W) && (max_tries >= MIN_MAX_TRIES) && (lockout_cyc >= MIN_LOCKOUT_CYC);
  endfunction

endpackage

// File: rtl/code_lock_if.sv
// code_lock_if: front-panel bundle of the code lock.
//   inputs to the lock : b_in, b_valid, abort, relock, prog_en
//   outputs of the lock: unlock, locked_out, fail, tries_left
//   master = front-panel side (drives inputs), slave = the lock itself.
interface code_lock_if #(
  parameter int MAX_TRIES = 3
);
  localparam int TRIES_W = $clog2(MAX_TRIES + 1);

  logic               b_in;
  logic               b_valid;
  logic               abort;
  logic               relock;
  logic               prog_en;
  logic               unlock;
  logic               locked_out;
  logic               fail;
  logic [TRIES_W-1:0] tries_left;

  modport master (
    output b_in, b_valid, abort, relock, prog_en,
    input  unlock, locked_out, fail, tries_left
  );

  modport slave (
    input  b_in, b_valid, abort, relock, prog_en,
    output unlock, locked_out, fail, tries_left
  );

endinterface

// File: rtl/code_lock_collector.sv
// code_lock_collector: serial LSB-first accumulator shared by code entry and programming.
//   clk, clear    : clock and asynchronous active-low reset
//   bit_i/valid_i : serial bit and its qualifier
//   abort_i       : clears the bit counter; wins over valid_i
//   data_o        : registered accumulated bits
//   data_next_o   : accumulated bits including the bit accepted on this edge
//   done_o        : high on the cycle whose edge accepts the final bit
module code_lock_collector #(
  parameter int CODE_W = 6
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              bit_i,
  input  logic              valid_i,
  input  logic              abort_i,
  output logic [CODE_W-1:0] data_o,
  output logic [CODE_W-1:0] data_next_o,
  output logic              done_o
);

  localparam int CNT_W = $clog2(CODE_W + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(CODE_W - 1);

  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic [CODE_W-1:0] data_q;
  logic [CODE_W-1:0] data_d;
  logic              take_s;

  // Next counter/data: abort clears the count, otherwise a valid bit lands at [cnt].
  always_comb begin
    cnt_d  = cnt_q;
    data_d = data_q;
    take_s = 1'b0;
    if (abort_i) begin
      cnt_d = '0;
    end else if (valid_i) begin
      take_s = 1'b1;
      for (int i = 0; i < CODE_W; i++) begin
        if (cnt_q == CNT_W'(i)) begin
          data_d[i] = bit_i;
        end else begin
          data_d[i] = data_q[i];
        end
      end
      if (cnt_q == LAST_IDX) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter and accumulator registers.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      cnt_q  <= '0;
      data_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      data_q <= data_d;
    end
  end

  assign data_o      = data_q;
  assign data_next_o = data_d;
  assign done_o      = take_s && (cnt_q == LAST_IDX);

endmodule

// File: rtl/code_lock.sv
// code_lock: serial code lock with reprogrammable code, retry limit and timed lockout.
//   clk   : clock, rising edge
//   clear : asynchronous active-low reset (also restores DEFAULT_CODE)
//   bus   : code_lock_if slave (b_in/b_valid/abort/relock/prog_en in,
//           unlock/locked_out/fail/tries_left out, all outputs registered)
module code_lock
  import code_lock_pkg::*;
#(
  parameter int                CODE_W       = 6,
  parameter logic [CODE_W-1:0] DEFAULT_CODE = CODE_W'(6'b101100),
  parameter int                MAX_TRIES    = 3,
  parameter int                LOCKOUT_CYC  = 16
) (
  input logic        clk,
  input logic        clear,
  code_lock_if.slave bus
);

  localparam int TRIES_W = $clog2(MAX_TRIES + 1);
  localparam int TIMER_W = $clog2(LOCKOUT_CYC + 1);
  localparam logic [TRIES_W-1:0] TRIES_FULL = TRIES_W'(MAX_TRIES);
  localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(LOCKOUT_CYC);

  if (!params_legal(CODE_W, MAX_TRIES, LOCKOUT_CYC)) begin : g_param_check
    $error("code_lock: CODE_W, MAX_TRIES and LOCKOUT_CYC must all be >= 1");
  end

  code_lock_state_t   state_q;
  code_lock_state_t   state_d;
  logic [TRIES_W-1:0] tries_q;
  logic [TRIES_W-1:0] tries_d;
  logic [TRIES_W-1:0] tries_dec_s;
  logic [TIMER_W-1:0] timer_q;
  logic [TIMER_W-1:0] timer_d;
  logic [CODE_W-1:0]  code_q;
  logic [CODE_W-1:0]  code_d;
  logic               unlock_q;
  logic               unlock_d;
  logic               locked_out_q;
  logic               locked_out_d;
  logic               fail_q;
  logic               fail_d;

  logic               col_valid_s;
  logic               col_clr_s;
  logic               col_done_s;
  logic [CODE_W-1:0]  col_data_s;
  logic [CODE_W-1:0]  col_data_next_s;

  code_lock_collector #(
    .CODE_W (CODE_W)
  ) u_collector (
    .clk         (clk),
    .clear       (clear),
    .bit_i       (bus.b_in),
    .valid_i     (col_valid_s),
    .abort_i     (col_clr_s),
    .data_o      (col_data_s),
    .data_next_o (col_data_next_s),
    .done_o      (col_done_s)
  );

  // Collector steering: bits only count in COLLECT/PROGRAM; elsewhere the counter is held at 0
  // so that PROGRAM and the next COLLECT always start from bit 0.
  always_comb begin
    col_valid_s = 1'b0;
    col_clr_s   = 1'b1;
    case (state_q)
      COLLECT: begin
        col_valid_s = bus.b_valid;
        col_clr_s   = bus.abort;
      end
      PROGRAM: begin
        col_valid_s = bus.b_valid;
        col_clr_s   = bus.abort | bus.relock;
      end
      default: begin
        col_valid_s = 1'b0;
        col_clr_s   = 1'b1;
      end
    endcase
  end

  // Saturating decrement so tries_left can never wrap below zero.
  always_comb begin
    if (tries_q != '0) begin
      tries_dec_s = tries_q - TRIES_W'(1);
    end else begin
      tries_dec_s = '0;
    end
  end

  // Next-state and next-output logic; outputs are derived from the next state and registered.
  always_comb begin
    state_d = state_q;
    tries_d = tries_q;
    timer_d = timer_q;
    code_d  = code_q;
    fail_d  = 1'b0;
    case (state_q)
      COLLECT: begin
        if (col_done_s) begin
          state_d = CHECK;
        end else begin
          state_d = COLLECT;
        end
      end
      CHECK: begin
        if (col_data_s == code_q) begin
          state_d = OPEN;
          tries_d = TRIES_FULL;
        end else begin
          fail_d  = 1'b1;
          tries_d = tries_dec_s;
          if (tries_dec_s == '0) begin
            state_d = LOCKOUT;
            timer_d = TIMER_LOAD;
          end else begin
            state_d = COLLECT;
          end
        end
      end
      OPEN: begin
        if (bus.relock) begin
          state_d = COLLECT;
        end else if (bus.prog_en) begin
          state_d = PROGRAM;
        end else begin
          state_d = OPEN;
        end
      end
      PROGRAM: begin
        if (bus.relock) begin
          state_d = COLLECT;
        end else if (bus.abort) begin
          state_d = OPEN;
        end else if (col_done_s) begin
          code_d  = col_data_next_s;
          state_d = OPEN;
        end else begin
          state_d = PROGRAM;
        end
      end
      LOCKOUT: begin
        // Leave on the edge where the timer reads 1 (0 only if the state is somehow corrupted).
        if (timer_q <= TIMER_W'(1)) begin
          state_d = COLLECT;
          tries_d = TRIES_FULL;
          timer_d = '0;
        end else begin
          timer_d = timer_q - TIMER_W'(1);
        end
      end
      default: begin
        state_d = COLLECT;
        tries_d = TRIES_FULL;
        timer_d = '0;
      end
    endcase
    unlock_d     = (state_d == OPEN) || (state_d == PROGRAM);
    locked_out_d = (state_d == LOCKOUT);
  end

  // State, counters, code store and registered outputs.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state_q      <= COLLECT;
      tries_q      <= TRIES_FULL;
      timer_q      <= '0;
      code_q       <= DEFAULT_CODE;
      unlock_q     <= 1'b0;
      locked_out_q <= 1'b0;
      fail_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      tries_q      <= tries_d;
      timer_q      <= timer_d;
      code_q       <= code_d;
      unlock_q     <= unlock_d;
      locked_out_q <= locked_out_d;
      fail_q       <= fail_d;
    end
  end

  assign bus.unlock     = unlock_q;
  assign bus.locked_out = locked_out_q;
  assign bus.fail       = fail_q;
  assign bus.tries_left = tries_q;

endmodule

// File: tb/tb_code_lock.sv
module tb_code_lock;

  logic clk;
  logic clear;
  int   sel;
  int   n_chk;
  int   n_fail;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  code_lock_if #(.MAX_TRIES(3)) if0 ();
  code_lock_if #(.MAX_TRIES(1)) if1 ();

  code_lock dut0 (
    .clk   (clk),
    .clear (clear),
    .bus   (if0)
  );

  code_lock #(
    .CODE_W       (8),
    .DEFAULT_CODE (8'hA5),
    .MAX_TRIES    (1),
    .LOCKOUT_CYC  (4)
  ) dut1 (
    .clk   (clk),
    .clear (clear),
    .bus   (if1)
  );

  typedef enum int {OP_ENTRY, OP_RELOCK, OP_PROG} op_e;

  typedef struct {
    op_e        op;
    logic [7:0] data;
    string      nm;
    logic       u;
    logic       lo;
    logic       f;
    logic [3:0] t;
  } vec_t;

  typedef struct {
    string      nm;
    logic       u;
    logic       lo;
    logic       f;
    logic [3:0] t;
  } exp_t;

  vec_t vecs [10];
  exp_t sb_q [$];

  function automatic logic u_out();
    return (sel == 0) ? if0.unlock : if1.unlock;
  endfunction

  function automatic logic lo_out();
    return (sel == 0) ? if0.locked_out : if1.locked_out;
  endfunction

  function automatic logic f_out();
    return (sel == 0) ? if0.fail : if1.fail;
  endfunction

  function automatic logic [3:0] t_out();
    return (sel == 0) ? {2'b00, if0.tries_left} : {3'b000, if1.tries_left};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle_all();
    if0.b_in = 1'b0; if0.b_valid = 1'b0; if0.abort = 1'b0; if0.relock = 1'b0; if0.prog_en = 1'b0;
    if1.b_in = 1'b0; if1.b_valid = 1'b0; if1.abort = 1'b0; if1.relock = 1'b0; if1.prog_en = 1'b0;
  endtask

  // One clock: drive inputs after a negedge, let the posedge take them, return at the next negedge.
  task automatic cycle(input logic b, input logic v, input logic ab, input logic rl, input logic pe);
    if (sel == 0) begin
      if0.b_in = b; if0.b_valid = v; if0.abort = ab; if0.relock = rl; if0.prog_en = pe;
    end else begin
      if1.b_in = b; if1.b_valid = v; if1.abort = ab; if1.relock = rl; if1.prog_en = pe;
    end
    @(posedge clk);
    @(negedge clk);
    idle_all();
  endtask

  task automatic sb_push(input string nm, input logic u, input logic lo, input logic f, input logic [3:0] t);
    exp_t e;
    e.nm = nm; e.u = u; e.lo = lo; e.f = f; e.t = t;
    sb_q.push_back(e);
  endtask

  task automatic sb_pop();
    exp_t e;
    if (sb_q.size() == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL scoreboard_empty: got no queued expectation, required one");
    end else begin
      e = sb_q.pop_front();
      chk({e.nm, "/unlock"},     {31'd0, u_out()},  {31'd0, e.u});
      chk({e.nm, "/locked_out"}, {31'd0, lo_out()}, {31'd0, e.lo});
      chk({e.nm, "/fail"},       {31'd0, f_out()},  {31'd0, e.f});
      chk({e.nm, "/tries_left"}, {28'd0, t_out()},  {28'd0, e.t});
    end
  endtask

  task automatic send_bits(input logic [7:0] d, input int w);
    for (int i = 0; i < w; i++) begin
      cycle(d[i], 1'b1, 1'b0, 1'b0, 1'b0);
    end
  endtask

  // Full entry; the result is visible after the edge following the last bit.
  task automatic entry(input logic [7:0] d, input int w, input string nm,
                       input logic u, input logic lo, input logic f, input logic [3:0] t);
    send_bits(d, w);
    sb_push(nm, u, lo, f, t);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    sb_pop();
    if (f && !lo) begin
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk({nm, "/fail_one_cycle"}, {31'd0, f_out()}, 32'd0);
    end
  endtask

  task automatic relock_op(input string nm, input logic [3:0] t);
    sb_push(nm, 1'b0, 1'b0, 1'b0, t);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    sb_pop();
  endtask

  task automatic prog_op(input logic [7:0] d, input int w, input string nm, input logic [3:0] t);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk({nm, "/in_program_unlock"}, {31'd0, u_out()}, 32'd1);
    send_bits(d, w);
    sb_push(nm, 1'b1, 1'b0, 1'b0, t);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    sb_pop();
  endtask

  // Called right after the edge that entered LOCKOUT; feeds bits that must be ignored.
  task automatic lockout_len(input string nm, input int exp_len, input logic [3:0] t_full);
    int n = 1;
    for (int k = 0; k < 40; k++) begin
      cycle(1'($urandom_range(0, 1)), 1'b1, 1'b0, 1'b0, 1'b0);
      if (lo_out()) n++;
      else break;
    end
    chk({nm, "/length"}, n, exp_len);
    chk({nm, "/tries_restored"}, {28'd0, t_out()}, {28'd0, t_full});
  endtask

  task automatic pulse_clear(input string nm, input logic [3:0] t_full);
    #2 clear = 1'b0;
    #1;
    chk({nm, "/unlock"},     {31'd0, u_out()},  32'd0);
    chk({nm, "/locked_out"}, {31'd0, lo_out()}, 32'd0);
    chk({nm, "/fail"},       {31'd0, f_out()},  32'd0);
    chk({nm, "/tries_left"}, {28'd0, t_out()},  {28'd0, t_full});
    @(negedge clk);
    clear = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, required end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk  = 0;
    n_fail = 0;
    sel    = 0;
    idle_all();
    clear = 1'b0;

    vecs[0] = '{OP_ENTRY,  8'h2C, "open_default",   1'b1, 1'b0, 1'b0, 4'd3};
    vecs[1] = '{OP_RELOCK, 8'h00, "relock_1",       1'b0, 1'b0, 1'b0, 4'd3};
    vecs[2] = '{OP_ENTRY,  8'h00, "wrong_zeros",    1'b0, 1'b0, 1'b1, 4'd2};
    vecs[3] = '{OP_ENTRY,  8'h3F, "wrong_ones",     1'b0, 1'b0, 1'b1, 4'd1};
    vecs[4] = '{OP_ENTRY,  8'h2C, "open_restores",  1'b1, 1'b0, 1'b0, 4'd3};
    vecs[5] = '{OP_PROG,   8'h13, "program_13",     1'b1, 1'b0, 1'b0, 4'd3};
    vecs[6] = '{OP_RELOCK, 8'h00, "relock_2",       1'b0, 1'b0, 1'b0, 4'd3};
    vecs[7] = '{OP_ENTRY,  8'h2C, "old_code_fails", 1'b0, 1'b0, 1'b1, 4'd2};
    vecs[8] = '{OP_ENTRY,  8'h13, "new_code_opens", 1'b1, 1'b0, 1'b0, 4'd3};
    vecs[9] = '{OP_RELOCK, 8'h00, "relock_3",       1'b0, 1'b0, 1'b0, 4'd3};

    repeat (2) @(negedge clk);
    chk("reset/unlock",     {31'd0, if0.unlock},     32'd0);
    chk("reset/locked_out", {31'd0, if0.locked_out}, 32'd0);
    chk("reset/fail",       {31'd0, if0.fail},       32'd0);
    chk("reset/tries_left", {30'd0, if0.tries_left}, 32'd3);
    chk("reset/w8_tries",   {31'd0, if1.tries_left}, 32'd1);
    clear = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 10; v++) begin
      case (vecs[v].op)
        OP_ENTRY:  entry(vecs[v].data, 6, vecs[v].nm, vecs[v].u, vecs[v].lo, vecs[v].f, vecs[v].t);
        OP_RELOCK: relock_op(vecs[v].nm, vecs[v].t);
        OP_PROG:   prog_op(vecs[v].data, 6, vecs[v].nm, vecs[v].t);
        default:   chk("bad_op", 32'd1, 32'd0);
      endcase
    end

    // Abort after 3 bits costs no attempt.
    send_bits(8'h13, 3);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("abort/tries_left", {28'd0, t_out()}, 32'd3);
    chk("abort/fail",       {31'd0, f_out()}, 32'd0);
    entry(8'h13, 6, "after_abort", 1'b1, 1'b0, 1'b0, 4'd3);
    relock_op("relock_4", 4'd3);

    // Abort together with b_valid: that bit is discarded.
    send_bits(8'h13, 2);
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    entry(8'h13, 6, "abort_with_valid", 1'b1, 1'b0, 1'b0, 4'd3);
    relock_op("relock_5", 4'd3);

    // Three failures, 16-cycle lockout with ignored bits, then an immediate correct entry.
    entry(8'h00, 6, "lk_fail1", 1'b0, 1'b0, 1'b1, 4'd2);
    entry(8'h00, 6, "lk_fail2", 1'b0, 1'b0, 1'b1, 4'd1);
    entry(8'h00, 6, "lk_fail3", 1'b0, 1'b1, 1'b1, 4'd0);
    lockout_len("lockout", 16, 4'd3);
    entry(8'h13, 6, "after_lockout", 1'b1, 1'b0, 1'b0, 4'd3);

    // Clear during PROGRAM: default code is back.
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    send_bits(8'h38, 3);
    pulse_clear("clear_in_program", 4'd3);
    entry(8'h13, 6, "programmed_code_lost", 1'b0, 1'b0, 1'b1, 4'd2);
    entry(8'h2C, 6, "default_after_clear", 1'b1, 1'b0, 1'b0, 4'd3);

    // Clear during LOCKOUT after programming a different code.
    prog_op(8'h38, 6, "program_38", 4'd3);
    relock_op("relock_6", 4'd3);
    entry(8'h00, 6, "cl_fail1", 1'b0, 1'b0, 1'b1, 4'd2);
    entry(8'h00, 6, "cl_fail2", 1'b0, 1'b0, 1'b1, 4'd1);
    entry(8'h00, 6, "cl_fail3", 1'b0, 1'b1, 1'b1, 4'd0);
    repeat (3) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("cl/still_locked", {31'd0, lo_out()}, 32'd1);
    pulse_clear("clear_in_lockout", 4'd3);
    entry(8'h38, 6, "code38_lost", 1'b0, 1'b0, 1'b1, 4'd2);
    entry(8'h2C, 6, "default_restored", 1'b1, 1'b0, 1'b0, 4'd3);
    relock_op("relock_7", 4'd3);

    // CODE_W=8, MAX_TRIES=1, LOCKOUT_CYC=4 instance.
    sel = 1;
    entry(8'h00, 8, "w8_fail", 1'b0, 1'b1, 1'b1, 4'd0);
    lockout_len("w8_lockout", 4, 4'd1);
    entry(8'hA5, 8, "w8_open", 1'b1, 1'b0, 1'b0, 4'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/code_lock.md
# code_lock

Parametrised serial code lock with configurable code width, a reprogrammable code, a retry limit and a timed lockout. Code bits arrive serially, LSB first, qualified by a valid strobe. A full entry is compared against the stored code. After too many failed entries, input is ignored for a fixed number of cycles. It sits beside the front-panel input logic and drives the unlock enable for downstream actuators.

## Interface
- `CODE_W`, default 6: code length in bits; must be ≥1.
- `DEFAULT_CODE`, default 6'b101100: code loaded at reset; width `CODE_W`.
- `MAX_TRIES`, default 3: failed entries allowed before lockout; must be ≥1.
- `LOCKOUT_CYC`, default 16: lockout duration in clk cycles; must be ≥1.
- `clk`, in, 1: single clock; all state updates on its rising edge.
- `clear`, in, 1: asynchronous, active-low reset.
- `b_in`, in, 1: serial code bit.
- `b_valid`, in, 1: `b_in` is accepted on this edge.
- `abort`, in, 1: discards the partial entry or programming sequence.
- `relock`, in, 1: closes the lock; meaningful in OPEN and PROGRAM.
- `prog_en`, in, 1: starts reprogramming; meaningful only in OPEN.
- `unlock`, out, 1: high while in OPEN or PROGRAM.
- `locked_out`, out, 1: high while in LOCKOUT.
- `fail`, out, 1: one-cycle pulse per mismatched entry.
- `tries_left`, out, `$clog2(MAX_TRIES+1)`: remaining attempts.

## Operation
- Reset values:
  - `unlock`=0, `locked_out`=0, `fail`=0, `tries_left`=`MAX_TRIES`.
  - Code register = `DEFAULT_CODE`, bit count = 0, state = COLLECT.
- **COLLECT**
  - Each `b_valid` writes `b_in` to entry bit [cnt] and increments cnt.
  - Accepting bit `CODE_W`-1 sends the FSM to CHECK and clears cnt.
  - `abort` clears cnt and costs no attempt.
- **CHECK** (exactly one cycle; `b_valid` ignored)
  - Match: go to OPEN; `tries_left` is restored to `MAX_TRIES`.
  - Mismatch: `fail` pulses and `tries_left` decrements.
    - If the new value is 0: go to LOCKOUT and load the timer with `LOCKOUT_CYC`.
    - Otherwise: go to COLLECT.
- **OPEN**
  - `relock`: go to COLLECT.
  - `prog_en`: go to PROGRAM with cnt=0.
  - `b_valid` is ignored.
- **PROGRAM**
  - Each `b_valid` fills a shadow register, LSB first.
  - After bit `CODE_W`-1, the shadow is copied to the code register and the FSM returns to OPEN.
  - `abort`: shadow discarded, code unchanged, return to OPEN.
  - `relock`: shadow discarded, go to COLLECT.
- **LOCKOUT**
  - All inputs are ignored.
  - The timer decrements each cycle.
  - The edge on which the timer reads 1 moves the FSM to COLLECT and restores `tries_left` to `MAX_TRIES`.
- **Simultaneous events**
  - `abort` beats `b_valid`: the bit is discarded.
  - `relock` beats `prog_en`, `abort` and `b_valid`.
  - In CHECK and LOCKOUT, every input is ignored.
- **Widths**
  - cnt: `$clog2(CODE_W+1)`.
  - timer: `$clog2(LOCKOUT_CYC+1)`.
  - `tries_left` never wraps below 0 or above `MAX_TRIES`.
- **Reset mid-operation:** `clear` low in any state immediately forces the reset values.
  - Partial entries are lost.
  - A programmed code reverts to `DEFAULT_CODE`.

## Timing
- Let E0 be the edge accepting the last code bit, and E1 the next edge.
- Match: `unlock` rises after E1, one cycle after the last bit.
- Mismatch: `fail` is high for exactly the cycle following E1; `tries_left` updates at E1.
- Lockout: `locked_out` is high for exactly `LOCKOUT_CYC` cycles, starting after E1.
  - A bit presented on the first cycle after lockout is accepted.
- `relock` at edge R: `unlock` is low after R; a `b_valid` at R+1 is accepted as bit 0.
- Programming: the new code is effective from the edge after the last programming bit.
  - An entry started after `relock` is compared against the new code.
- All outputs are registered; there is no combinational input-to-output path.

## Structure
- Package `code_lock_pkg` holds:
  - the state enum typedef `code_lock_state_t` (COLLECT, CHECK, OPEN, PROGRAM, LOCKOUT);
  - the parameter-legality check macros/constants.
- Sub-module `code_lock_collector` (`CODE_W`) holds the serial LSB-first accumulator:
  - bit counter, `done` pulse on the final bit, `abort` clear;
  - instantiated once; reused for both entry and programming, with its output routed by state.

## Test plan
- Default params, reset, enter 101100 LSB-first: `unlock`=1 one cycle after the last bit; `tries_left`=3.
- Enter 000000 three times: `fail` pulses 3×; `tries_left` goes 2,1,0; `locked_out` high exactly 16 cycles; bits during lockout ignored; then 101100 unlocks.
- Unlock, `prog_en`, program 010011, `relock`: old code 101100 fails and the new code unlocks.
- `abort` after 3 bits, then correct code: unlock succeeds and no attempt is consumed.
  - Repeat with `abort` and `b_valid` in the same cycle: that bit is discarded.
- `clear` asserted during PROGRAM and during LOCKOUT: all outputs return to reset values; `DEFAULT_CODE` is restored.
- `CODE_W`=8, `MAX_TRIES`=1, `LOCKOUT_CYC`=4: one wrong 8-bit entry locks out for 4 cycles; the correct entry then unlocks.
